rename_map: RTL and testbench

Register alias table plus physical-register free list, sitting in rename and terminating the ROB's retire-side packets. Renames up to one uop per cycle at rn0: it looks up source mappings, allocates a new PRF id for the destination, and reports the previous mapping for the ROB to keep as `pdst_old`. It consumes the reclaim packet at retire, which returns the old PRF id to the free list. It also consumes the restore walk after a nuke: it writes `pdst_old` back into the map and frees the squashed PRF id.

---
 rtl/rename_map.sv | 219 +++++++++++++++++++++
 tb/tb_rename_map.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map.sv
// rename_map: register alias table plus physical-register free list.
//
// Renames at most one uop per cycle in rn0. Source and pdst_old lookups are
// combinational off the current map. A destination write pops the free-list
// head and points the map at it on the clock edge. Retire reclaims and
// post-nuke restore steps push ids back at the tail. Restore steps also
// rewrite the map.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   rat_ready_rn0            rename may proceed this cycle
//   rn_valid_rn0             uop renamed this cycle
//   rn_src_gpr_rn0[k]        source GPRs, rn_src_prfid_rn0[k] current mappings
//   rn_dst_valid_rn0/_gpr    destination write request
//   rn_pdst_rn0              free-list head (new PRF id)
//   rn_pdst_old_rn0          current mapping of the destination GPR
//   reclaim_valid/prfid_rb1  retire-side return of an old PRF id
//   restore_valid/gpr/prfid  one restore-walk step
//   nuke_valid_rb1           flush at ROB head, enters recovery
//   resume_fetch_rbx         restore walk finished, leaves recovery
//   free_cnt                 free-list occupancy

module rename_map #(
  parameter int NUM_GPRS = 32,
  parameter int NUM_PRF  = 64,
  parameter int NUM_SRCS = 2,
  localparam int PW = $clog2(NUM_PRF),
  localparam int GW = $clog2(NUM_GPRS),
  localparam int CW = $clog2(NUM_PRF) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          rat_ready_rn0,
  input  logic          rn_valid_rn0,
  input  logic [GW-1:0] rn_src_gpr_rn0   [NUM_SRCS],
  output logic [PW-1:0] rn_src_prfid_rn0 [NUM_SRCS],
  input  logic          rn_dst_valid_rn0,
  input  logic [GW-1:0] rn_dst_gpr_rn0,
  output logic [PW-1:0] rn_pdst_rn0,
  output logic [PW-1:0] rn_pdst_old_rn0,
  input  logic          reclaim_valid_rb1,
  input  logic [PW-1:0] reclaim_prfid_rb1,
  input  logic          restore_valid_rbx,
  input  logic [GW-1:0] restore_gpr_rbx,
  input  logic [PW-1:0] restore_prfid_rbx,
  input  logic          nuke_valid_rb1,
  input  logic          resume_fetch_rbx,
  output logic [CW-1:0] free_cnt
);

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;

  logic [PW-1:0] map_r  [NUM_GPRS];
  logic [PW-1:0] fl_r   [NUM_PRF];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] cnt_r;

  logic          alloc_s;
  logic [1:0]    push_cnt_s;
  logic [PW-1:0] restore_slot_s;
  logic [PW-1:0] restore_old_s;
  logic [CW-1:0] cnt_nxt_s;

  // Pointer advance; power-of-two depth makes the wrap implicit.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [PW-1:0] n);
    return p + n;
  endfunction

  // Recovery state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= NORMAL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Recovery next-state: nuke enters, resume leaves.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      NORMAL: begin
        if (nuke_valid_rb1) begin
          state_nxt_s = RECOVER;
        end else begin
          state_nxt_s = NORMAL;
        end
      end
      RECOVER: begin
        if (resume_fetch_rbx) begin
          state_nxt_s = NORMAL;
        end else begin
          state_nxt_s = RECOVER;
        end
      end
      default: state_nxt_s = NORMAL;
    endcase
  end

  // Push/pop bookkeeping. A reclaim takes the tail slot, so a restore in the
  // same cycle lands one slot later.
  always_comb begin
    alloc_s        = rn_valid_rn0 & rn_dst_valid_rn0 & (rn_dst_gpr_rn0 != GW'(0));
    push_cnt_s     = {1'b0, reclaim_valid_rb1} + {1'b0, restore_valid_rbx};
    restore_old_s  = map_r[restore_gpr_rbx];
    if (reclaim_valid_rb1) begin
      restore_slot_s = ptr_add(tail_r, PW'(1));
    end else begin
      restore_slot_s = tail_r;
    end
    cnt_nxt_s      = cnt_r + CW'(push_cnt_s) - CW'(alloc_s);
  end

  // Map table, free-list storage and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GPRS; i++) begin
        map_r[i] <= PW'(i);
      end
      // The first NUM_PRF-NUM_GPRS slots hold the ids not used by the identity map.
      for (int i = 0; i < NUM_PRF; i++) begin
        fl_r[i] <= PW'(i + NUM_GPRS);
      end
      head_r <= PW'(0);
      tail_r <= PW'(NUM_PRF - NUM_GPRS);
      cnt_r  <= CW'(NUM_PRF - NUM_GPRS);
    end else begin
      if (alloc_s) begin
        map_r[rn_dst_gpr_rn0] <= fl_r[head_r];
        head_r                <= ptr_add(head_r, PW'(1));
      end
      // Rename is blocked during recovery, so this never collides with the write above.
      if (restore_valid_rbx && (restore_gpr_rbx != GW'(0))) begin
        map_r[restore_gpr_rbx] <= restore_prfid_rbx;
      end
      if (reclaim_valid_rb1) begin
        fl_r[tail_r] <= reclaim_prfid_rb1;
      end
      if (restore_valid_rbx) begin
        fl_r[restore_slot_s] <= restore_old_s;
      end
      tail_r <= ptr_add(tail_r, PW'(push_cnt_s));
      cnt_r  <= cnt_nxt_s;
    end
  end

  // Zero-latency rn0 lookups against the pre-update map.
  always_comb begin
    for (int k = 0; k < NUM_SRCS; k++) begin
      rn_src_prfid_rn0[k] = map_r[rn_src_gpr_rn0[k]];
    end
    rn_pdst_rn0     = fl_r[head_r];
    rn_pdst_old_rn0 = map_r[rn_dst_gpr_rn0];
    free_cnt        = cnt_r;
    // The nuke term is live in its own cycle; a reclaim at empty does not bypass.
    rat_ready_rn0   = (state_r == NORMAL) & ~nuke_valid_rb1 & (cnt_r != CW'(0));
  end

  rename_map_chk #(
    .NUM_GPRS (NUM_GPRS),
    .NUM_PRF  (NUM_PRF)
  ) u_chk (
    .clk           (clk),
    .reset         (reset),
    .rn_valid      (rn_valid_rn0),
    .ready         (rat_ready_rn0),
    .restore_valid (restore_valid_rbx),
    .restore_gpr   (restore_gpr_rbx),
    .resume        (resume_fetch_rbx),
    .in_recover    (state_r == RECOVER),
    .free_cnt      (cnt_r)
  );

endmodule

// rename_map_chk: illegal-input checks for rename_map.
// Ports: clk/reset, rename handshake, restore/resume controls, recovery flag
// and the registered free-list count.
module rename_map_chk #(
  parameter int NUM_GPRS = 32,
  parameter int NUM_PRF  = 64,
  localparam int GW = $clog2(NUM_GPRS),
  localparam int CW = $clog2(NUM_PRF) + 1
) (
  input logic          clk,
  input logic          reset,
  input logic          rn_valid,
  input logic          ready,
  input logic          restore_valid,
  input logic [GW-1:0] restore_gpr,
  input logic          resume,
  input logic          in_recover,
  input logic [CW-1:0] free_cnt
);

  // Protocol checks, sampled outside reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_rn_ready: assert (!(rn_valid && !ready))
        else $error("rename_map: rename while not ready");
      a_restore_state: assert (!(restore_valid && !in_recover))
        else $error("rename_map: restore outside recovery");
      a_restore_gpr0: assert (!(restore_valid && (restore_gpr == GW'(0))))
        else $error("rename_map: restore to gpr 0");
      a_resume_state: assert (!(resume && !in_recover))
        else $error("rename_map: resume outside recovery");
      a_overflow: assert (free_cnt <= CW'(NUM_PRF - NUM_GPRS))
        else $error("rename_map: free list overflow");
    end
  end

endmodule

// File: tb/tb_rename_map.sv
// Directed self-checking bench for rename_map.
module tb_rename_map;

  logic       clk;
  logic       reset;
  logic       rat_ready;
  logic       rn_valid;
  logic [4:0] src_gpr   [2];
  logic [5:0] src_prfid [2];
  logic       dst_valid;
  logic [4:0] dst_gpr;
  logic [5:0] pdst;
  logic [5:0] pdst_old;
  logic       reclaim_valid;
  logic [5:0] reclaim_prfid;
  logic       restore_valid;
  logic [4:0] restore_gpr;
  logic [5:0] restore_prfid;
  logic       nuke;
  logic       resume;
  logic [6:0] free_cnt;

  int checks   = 0;
  int failures = 0;

  rename_map dut (
    .clk               (clk),
    .reset             (reset),
    .rat_ready_rn0     (rat_ready),
    .rn_valid_rn0      (rn_valid),
    .rn_src_gpr_rn0    (src_gpr),
    .rn_src_prfid_rn0  (src_prfid),
    .rn_dst_valid_rn0  (dst_valid),
    .rn_dst_gpr_rn0    (dst_gpr),
    .rn_pdst_rn0       (pdst),
    .rn_pdst_old_rn0   (pdst_old),
    .reclaim_valid_rb1 (reclaim_valid),
    .reclaim_prfid_rb1 (reclaim_prfid),
    .restore_valid_rbx (restore_valid),
    .restore_gpr_rbx   (restore_gpr),
    .restore_prfid_rbx (restore_prfid),
    .nuke_valid_rb1    (nuke),
    .resume_fetch_rbx  (resume),
    .free_cnt          (free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rn_valid      = 1'b0;
    dst_valid     = 1'b0;
    dst_gpr       = 5'd0;
    src_gpr[0]    = 5'd0;
    src_gpr[1]    = 5'd0;
    reclaim_valid = 1'b0;
    reclaim_prfid = 6'd0;
    restore_valid = 1'b0;
    restore_gpr   = 5'd0;
    restore_prfid = 6'd0;
    nuke          = 1'b0;
    resume        = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic rename(input logic [4:0] d);
    rn_valid  = 1'b1;
    dst_valid = 1'b1;
    dst_gpr   = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    src_gpr[0] = 5'd7;
    src_gpr[1] = 5'd9;
    dst_gpr    = 5'd4;
    #1;
    chk("rst_ready",    32'(rat_ready),    32'd1);
    chk("rst_free_cnt", 32'(free_cnt),     32'd32);
    chk("rst_pdst",     32'(pdst),         32'd32);
    chk("rst_src0",     32'(src_prfid[0]), 32'd7);
    chk("rst_src1",     32'(src_prfid[1]), 32'd9);
    chk("rst_pdst_old", 32'(pdst_old),     32'd4);

    // Rename dst 5, srcs 5 and 6
    idle();
    rename(5'd5);
    src_gpr[0] = 5'd5;
    src_gpr[1] = 5'd6;
    #1;
    chk("t1_src0",     32'(src_prfid[0]), 32'd5);
    chk("t1_src1",     32'(src_prfid[1]), 32'd6);
    chk("t1_pdst",     32'(pdst),         32'd32);
    chk("t1_pdst_old", 32'(pdst_old),     32'd5);
    tick();
    idle();
    src_gpr[0] = 5'd5;
    #1;
    chk("t1_map5",     32'(src_prfid[0]), 32'd32);
    chk("t1_free_cnt", 32'(free_cnt),     32'd31);

    // 32 renames of dst 1 drain the free list
    do_reset();
    for (int i = 0; i < 32; i++) begin
      rename(5'd1);
      #1;
      chk("t2_pdst", 32'(pdst), 32'(32 + i));
      tick();
      idle();
    end
    #1;
    chk("t2_empty_cnt",   32'(free_cnt),  32'd0);
    chk("t2_empty_ready", 32'(rat_ready), 32'd0);
    reclaim_valid = 1'b1;
    reclaim_prfid = 6'd1;
    #1;
    chk("t2_ready_during_reclaim", 32'(rat_ready), 32'd0);
    tick();
    idle();
    #1;
    chk("t2_ready_after_reclaim", 32'(rat_ready), 32'd1);
    chk("t2_cnt_after_reclaim",   32'(free_cnt),  32'd1);
    chk("t2_pdst_after_reclaim",  32'(pdst),      32'd1);

    // Pop and push together for 33 cycles so head and tail both wrap
    for (int j = 0; j < 33; j++) begin
      rename(5'd1);
      reclaim_valid = 1'b1;
      reclaim_prfid = 6'(j + 2);
      #1;
      chk("t2_wrap_pdst",  32'(pdst),      32'(j + 1));
      chk("t2_wrap_ready", 32'(rat_ready), 32'd1);
      tick();
      idle();
    end
    #1;
    chk("t2_wrap_cnt",  32'(free_cnt), 32'd1);
    chk("t2_wrap_head", 32'(pdst),     32'd34);

    // Rename with dst 0 neither pops nor writes
    rename(5'd0);
    #1;
    chk("t3_pdst", 32'(pdst), 32'd34);
    tick();
    idle();
    #1;
    chk("t3_cnt",      32'(free_cnt),     32'd1);
    chk("t3_pdst_kept", 32'(pdst),        32'd34);
    chk("t3_map0",     32'(src_prfid[0]), 32'd0);

    // Two renames of dst 3, nuke, restore walk, resume
    do_reset();
    rename(5'd3);
    src_gpr[0] = 5'd3;
    #1;
    chk("t4_pdst_a",     32'(pdst),         32'd32);
    chk("t4_pdst_old_a", 32'(pdst_old),     32'd3);
    chk("t4_src_a",      32'(src_prfid[0]), 32'd3);
    tick();
    idle();
    rename(5'd3);
    #1;
    chk("t4_pdst_b",     32'(pdst),     32'd33);
    chk("t4_pdst_old_b", 32'(pdst_old), 32'd32);
    tick();
    idle();
    nuke = 1'b1;
    #1;
    chk("t4_ready_nuke", 32'(rat_ready), 32'd0);
    tick();
    idle();
    #1;
    chk("t4_ready_recover", 32'(rat_ready), 32'd0);
    chk("t4_cnt_pre",       32'(free_cnt),  32'd30);
    restore_valid = 1'b1;
    restore_gpr   = 5'd3;
    restore_prfid = 6'd32;
    tick();
    restore_prfid = 6'd3;
    src_gpr[0]    = 5'd3;
    #1;
    chk("t4_map3_step1", 32'(src_prfid[0]), 32'd32);
    tick();
    idle();
    src_gpr[0] = 5'd3;
    #1;
    chk("t4_map3_final", 32'(src_prfid[0]), 32'd3);
    chk("t4_cnt_final",  32'(free_cnt),     32'd32);
    chk("t4_ready_pre_resume", 32'(rat_ready), 32'd0);
    resume = 1'b1;
    tick();
    idle();
    #1;
    chk("t4_ready_resumed", 32'(rat_ready), 32'd1);
    for (int k = 0; k < 32; k++) begin
      rename(5'd4);
      #1;
      chk("t4_drain_pdst", 32'(pdst), (k < 30) ? 32'(34 + k) : ((k == 30) ? 32'd33 : 32'd32));
      tick();
      idle();
    end

    // Reclaim and restore in one cycle at free_cnt 10
    do_reset();
    for (int i = 0; i < 22; i++) begin
      rename(5'd7);
      tick();
      idle();
    end
    #1;
    chk("t5_cnt_pre", 32'(free_cnt), 32'd10);
    nuke = 1'b1;
    tick();
    idle();
    reclaim_valid = 1'b1;
    reclaim_prfid = 6'd20;
    restore_valid = 1'b1;
    restore_gpr   = 5'd7;
    restore_prfid = 6'd52;
    tick();
    idle();
    src_gpr[0] = 5'd7;
    #1;
    chk("t5_cnt_post", 32'(free_cnt),     32'd12);
    chk("t5_map7",     32'(src_prfid[0]), 32'd52);
    resume = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 12; k++) begin
      rename(5'd8);
      #1;
      chk("t5_drain_pdst", 32'(pdst), (k < 10) ? 32'(54 + k) : ((k == 10) ? 32'd20 : 32'd53));
      tick();
      idle();
    end

    // Reset while in recovery with map[3]=40
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rename(5'd2);
      tick();
      idle();
    end
    rename(5'd3);
    #1;
    chk("t6_pdst", 32'(pdst), 32'd40);
    tick();
    idle();
    nuke = 1'b1;
    tick();
    idle();
    src_gpr[0] = 5'd3;
    #1;
    chk("t6_map3",        32'(src_prfid[0]), 32'd40);
    chk("t6_ready_recov", 32'(rat_ready),    32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_map3_rst",  32'(src_prfid[0]), 32'd3);
    chk("t6_cnt_rst",   32'(free_cnt),     32'd32);
    chk("t6_ready_rst", 32'(rat_ready),    32'd1);
    chk("t6_pdst_rst",  32'(pdst),         32'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
